logic_scan_ctrl: RTL and testbench

- Truth-table scan sequencer for the EGO1 combinational labs (3-input function, original and hazard-free forms side by side).
- Drives the shared 3-bit input vector in place of the switches and steps it through all 8 combinations, either on a timed tick or on a button.
- After each settle window, samples both function outputs into truth-table registers and flags any disagreement.
- Sits between the button/switch front end and the lab logic; its outputs feed the LEDs.

---
 rtl/logic_scan_pkg.sv | 24 ++
 rtl/logic_scan_ctrl_if.sv | 35 +++
 rtl/logic_scan_ctrl_tick_gen.sv | 33 +++
 rtl/logic_scan_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_logic_scan_ctrl.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/logic_scan_pkg.sv
// Shared types and constants for the truth-table scan sequencer.
// Holds the FSM state enum, vector sizing and the prescaler width helper.
package logic_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam int N_IN  = 3;
    localparam int N_VEC = 2 ** N_IN;
    localparam int SET_W = 4;

    // Width of the step prescaler; never below 1 bit.
    function automatic int presc_w(input int clk_hz, input int step_hz);
        int div;
        div = clk_hz / step_hz;
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/logic_scan_ctrl_if.sv
// Bundle between the lab front end / lab logic and the scan sequencer.
// slave: sequencer side (controls + f_a/f_b in, vector/tables/flags out).
// master: front-end / bench side, directions mirrored.
interface logic_scan_ctrl_if;
    import logic_scan_pkg::*;

    logic             start;
    logic             abort;
    logic             step_mode;
    logic             step_req;
    logic             f_a;
    logic             f_b;
    logic [N_IN-1:0]  vec_out;
    logic [N_VEC-1:0] table_a;
    logic [N_VEC-1:0] table_b;
    logic             busy;
    logic             done;
    logic             mismatch;
    logic [N_IN-1:0]  mismatch_idx;
    logic [7:0]       glitch_a;
    logic [7:0]       glitch_b;

    modport slave (
        input  start, abort, step_mode, step_req, f_a, f_b,
        output vec_out, table_a, table_b, busy, done,
        output mismatch, mismatch_idx, glitch_a, glitch_b
    );

    modport master (
        output start, abort, step_mode, step_req, f_a, f_b,
        input  vec_out, table_a, table_b, busy, done,
        input  mismatch, mismatch_idx, glitch_a, glitch_b
    );

endinterface

// File: rtl/logic_scan_ctrl_tick_gen.sv
// Free-running step prescaler: one-cycle tick every CLK_HZ/STEP_HZ cycles.
// Ports: clk, rst_n (async active-low), tick (out).
module scan_tick_gen
    import logic_scan_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int STEP_HZ = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int DIV = CLK_HZ / STEP_HZ;
    localparam int PW  = presc_w(CLK_HZ, STEP_HZ);

    logic [PW-1:0] cnt;
    logic          wrap;

    assign wrap = (cnt == PW'(DIV - 1));
    assign tick = wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PW'(1);
        end
    end

endmodule

// File: rtl/logic_scan_ctrl.sv
// Truth-table scan sequencer: steps the shared input vector through all
// combinations, samples f_a/f_b into tables and flags disagreements.
// Ports: clk, rst_n (async active-low), bus (logic_scan_ctrl_if.slave).
// Optional macro LOGIC_SCAN_GLITCH_EN enables f_a/f_b transition counters.
module logic_scan_ctrl
    import logic_scan_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int STEP_HZ    = 2,
    parameter int SETTLE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    logic_scan_ctrl_if.slave  bus
);

    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [N_IN-1:0]  VEC_LAST = N_IN'(N_VEC - 1);

    state_t state, state_n;

    logic             tick;
    logic             start_q, step_q;
    logic             start_edge, step_edge;
    logic             advance;
    logic             do_start, do_sample, do_next, do_fin;
    logic [SET_W-1:0] set_cnt;
    logic [N_IN-1:0]  vec;
    logic [N_IN-1:0]  mm_idx;
    logic [N_VEC-1:0] tab_a, tab_b;
    logic             busy_r, done_r, mm;

    scan_tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .STEP_HZ (STEP_HZ)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign start_edge = bus.start & ~start_q;
    assign step_edge  = bus.step_req & ~step_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            start_q <= bus.start;
            step_q  <= bus.step_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        do_start  = 1'b0;
        do_sample = 1'b0;
        do_next   = 1'b0;
        do_fin    = 1'b0;
        advance   = bus.step_mode ? step_edge : tick;
        if (bus.abort) begin
            state_n = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_edge) begin
                        do_start = 1'b1;
                        state_n  = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (set_cnt == SET_LAST) begin
                        state_n = ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    do_sample = 1'b1;
                    state_n   = ST_WAIT;
                end
                ST_WAIT: begin
                    if (advance) begin
                        if (vec == VEC_LAST) begin
                            do_fin  = 1'b1;
                            state_n = ST_DONE;
                        end else begin
                            do_next = 1'b1;
                            state_n = ST_SETTLE;
                        end
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_cnt <= '0;
            vec     <= '0;
            tab_a   <= '0;
            tab_b   <= '0;
            mm      <= 1'b0;
            mm_idx  <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            // Counter only runs in SETTLE, so each SETTLE entry starts at 0.
            if (state == ST_SETTLE) begin
                set_cnt <= set_cnt + SET_W'(1);
            end else begin
                set_cnt <= '0;
            end
            if (bus.abort) begin
                busy_r <= 1'b0;
                done_r <= 1'b0;
            end
            if (do_start) begin
                vec    <= '0;
                tab_a  <= '0;
                tab_b  <= '0;
                mm     <= 1'b0;
                mm_idx <= '0;
                busy_r <= 1'b1;
                done_r <= 1'b0;
            end
            if (do_sample) begin
                tab_a[vec] <= bus.f_a;
                tab_b[vec] <= bus.f_b;
                if ((bus.f_a != bus.f_b) && !mm) begin
                    mm     <= 1'b1;
                    mm_idx <= vec;
                end
            end
            if (do_next) begin
                vec <= vec + N_IN'(1);
            end
            if (do_fin) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end
        end
    end

`ifdef LOGIC_SCAN_GLITCH_EN
    logic       fa_q, fb_q;
    logic [7:0] g_a, g_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fa_q <= 1'b0;
            fb_q <= 1'b0;
            g_a  <= '0;
            g_b  <= '0;
        end else begin
            fa_q <= bus.f_a;
            fb_q <= bus.f_b;
            if (do_start) begin
                g_a <= '0;
                g_b <= '0;
            end else if (state == ST_SETTLE) begin
                if ((bus.f_a != fa_q) && (g_a != 8'hFF)) begin
                    g_a <= g_a + 8'd1;
                end
                if ((bus.f_b != fb_q) && (g_b != 8'hFF)) begin
                    g_b <= g_b + 8'd1;
                end
            end
        end
    end

    assign bus.glitch_a = g_a;
    assign bus.glitch_b = g_b;
`else
    assign bus.glitch_a = '0;
    assign bus.glitch_b = '0;
`endif

    assign bus.vec_out      = vec;
    assign bus.table_a      = tab_a;
    assign bus.table_b      = tab_b;
    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.mismatch     = mm;
    assign bus.mismatch_idx = mm_idx;

endmodule

// File: tb/tb_logic_scan_ctrl.sv
// Directed bench for logic_scan_ctrl: auto/step scans, mismatch capture,
// abort/restart, busy start, async reset and glitch counting.
module tb_logic_scan_ctrl;
    import logic_scan_pkg::*;

`ifdef LOGIC_SCAN_GLITCH_EN
    localparam int GA = 5;
    localparam int GB = 3;
`else
    localparam int GA = 0;
    localparam int GB = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic inj_a = 1'b0;
    logic frc5  = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    logic_scan_ctrl_if bus ();

    function automatic logic fn(input logic [2:0] v);
        return v[0] ? v[1] : v[2];
    endfunction

    assign bus.f_a = fn(bus.vec_out) ^ inj_a;
    assign bus.f_b = fn(bus.vec_out) | (frc5 && (bus.vec_out == 3'd5));

    logic_scan_ctrl #(
        .CLK_HZ     (100),
        .STEP_HZ    (10),
        .SETTLE_CYC (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic pulse_step();
        @(negedge clk);
        bus.step_req = 1'b1;
        @(negedge clk);
        bus.step_req = 1'b0;
    endtask

    task automatic wait_vec(input logic [2:0] v, input string tag);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.vec_out == v) break;
        end
        chk(tag, 32'(bus.vec_out), 32'(v));
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.done) break;
        end
        chk(tag, 32'(bus.done), 32'd1);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.step_mode = 1'b0;
        bus.step_req  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_vec", 32'(bus.vec_out), 32'd0);
        chk("rst_tab", {bus.table_a, bus.table_b}, 32'd0);
        chk("rst_flags", {bus.busy, bus.done, bus.mismatch}, 32'd0);
        chk("rst_glitch", {bus.glitch_a, bus.glitch_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Auto scan, matching functions, glitch pulse at index 7.
        pulse_start();
        chk("a_busy", 32'(bus.busy), 32'd1);
        wait_vec(3'd7, "a_vec7");
        inj_a = 1'b1;
        @(negedge clk);
        inj_a = 1'b0;
        wait_done("a_done");
        chk("a_busy0", 32'(bus.busy), 32'd0);
        chk("a_tab_a", 32'(bus.table_a), 32'hD8);
        chk("a_tab_b", 32'(bus.table_b), 32'hD8);
        chk("a_mm", 32'(bus.mismatch), 32'd0);
        chk("a_vec", 32'(bus.vec_out), 32'd7);
        chk("a_gl_a", 32'(bus.glitch_a), 32'(GA));
        chk("a_gl_b", 32'(bus.glitch_b), 32'(GB));

        // Mismatch at index 5.
        frc5 = 1'b1;
        pulse_start();
        chk("m_done0", 32'(bus.done), 32'd0);
        wait_done("m_done");
        chk("m_tab_a", 32'(bus.table_a), 32'hD8);
        chk("m_tab_b", 32'(bus.table_b), 32'hF8);
        chk("m_mm", 32'(bus.mismatch), 32'd1);
        chk("m_idx", 32'(bus.mismatch_idx), 32'd5);
        frc5 = 1'b0;

        // Step mode: three steps, then a dropped step during SETTLE.
        bus.step_mode = 1'b1;
        pulse_start();
        chk("s_tab0", 32'(bus.table_a), 32'd0);
        repeat (8) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            pulse_step();
            repeat (8) @(negedge clk);
        end
        chk("s_vec3", 32'(bus.vec_out), 32'd3);
        chk("s_tab_a", 32'(bus.table_a), 32'h08);
        chk("s_busy", 32'(bus.busy), 32'd1);
        pulse_step();
        pulse_step();
        repeat (8) @(negedge clk);
        chk("s_drop", 32'(bus.vec_out), 32'd4);
        chk("s_tab4", 32'(bus.table_a), 32'h18);

        // Abort at index 4, start held off while abort is high.
        bus.abort = 1'b1;
        @(negedge clk);
        chk("ab_flags", {bus.busy, bus.done}, 32'd0);
        chk("ab_vec", 32'(bus.vec_out), 32'd4);
        chk("ab_tab", 32'(bus.table_a), 32'h18);
        pulse_start();
        @(negedge clk);
        chk("ab_prio", 32'(bus.busy), 32'd0);
        bus.abort = 1'b0;
        bus.step_mode = 1'b0;
        pulse_start();
        chk("rs_vec", 32'(bus.vec_out), 32'd0);
        chk("rs_tab", {bus.table_a, bus.table_b}, 32'd0);
        chk("rs_busy", 32'(bus.busy), 32'd1);

        // Start while busy is ignored.
        wait_vec(3'd2, "b_vec2");
        pulse_start();
        chk("b_norst", 32'(bus.vec_out), 32'd2);
        wait_done("b_done");
        chk("b_tab_a", 32'(bus.table_a), 32'hD8);
        chk("b_vec", 32'(bus.vec_out), 32'd7);

        // Async reset mid-SETTLE.
        pulse_start();
        wait_vec(3'd3, "r_vec3");
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_vec", 32'(bus.vec_out), 32'd0);
        chk("r_tab", {bus.table_a, bus.table_b}, 32'd0);
        chk("r_flags", {bus.busy, bus.done, bus.mismatch}, 32'd0);
        chk("r_glitch", {bus.glitch_a, bus.glitch_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
